// File: rtl/conv_sample_loader.sv
// Frame sequencer feeding the 64-way sample demux: streams up to DEPTH samples,
// zero-pads the remaining slots, then pulses frame_done.
module conv_sample_loader #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned SEL_W  = 6,
   parameter int unsigned DEPTH  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SEL_W:0]    len,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [SEL_W-1:0]  sel_out,
   output logic [DATA_W-1:0] data_out,
   output logic              wr_en,
   output logic              busy,
   output logic              frame_done,
   output logic              len_err
);

   localparam int unsigned IDX_W = SEL_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PAD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    len_q, len_d;
   logic [SEL_W-1:0]    sel_d;
   logic [DATA_W-1:0]   data_d;
   logic                wr_d, busy_d, done_d, err_d;
   logic                len_ok_c;

   assign in_ready = (state_q == LOAD);
   assign len_ok_c = (len != '0) && (len <= IDX_W'(DEPTH));

   // State, slot counter and registered demux/status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         sel_out    <= '0;
         data_out   <= '0;
         wr_en      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         sel_out    <= sel_d;
         data_out   <= data_d;
         wr_en      <= wr_d;
         busy       <= busy_d;
         frame_done <= done_d;
         len_err    <= err_d;
      end
   end

   // Next-state and next-output logic; DONE is the cycle showing the last write,
   // so frame_done registered from it lands in the following cycle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      sel_d   = sel_out;
      data_d  = data_out;
      wr_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len_ok_c) begin
                  len_d   = len;
                  idx_d   = '0;
                  state_d = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (in_valid) begin
               sel_d  = idx_q[SEL_W-1:0];
               data_d = in_data;
               wr_d   = 1'b1;
               idx_d  = idx_q + IDX_W'(1);
               if ((idx_q + IDX_W'(1)) == len_q) begin
                  state_d = (len_q == IDX_W'(DEPTH)) ? DONE : PAD;
               end
            end
         end
         PAD: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               sel_d  = idx_q[SEL_W-1:0];
               data_d = '0;
               wr_d   = 1'b1;
               idx_d  = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(DEPTH - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: doc/conv_sample_loader.md
# conv_sample_loader

Frame sequencer that sits directly upstream of the 64-way sample demultiplexer in the linear-convolution datapath. It accepts a variable-length frame of 16-bit samples over a valid/ready stream and drives the demux select and data lines, one write per cycle. It zero-pads the remaining slots so all 64 demux outputs are rewritten every frame, then signals frame completion to the convolution engine.

## Interface
Parameters:
- DATA_W, 16, sample width
- SEL_W, 6, demux select width
- DEPTH, 64, slots per frame (2**SEL_W)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame start request; sampled only in IDLE
- len  in  SEL_W+1  frame length in samples, legal 1..DEPTH; latched on accepted start
- abort  in  1  synchronous frame abort
- in_valid  in  1  upstream sample valid
- in_data  in  DATA_W  upstream sample
- in_ready  out  1  loader can accept a sample
- sel_out  out  SEL_W  demux select
- data_out  out  DATA_W  demux data
- wr_en  out  1  sel_out/data_out carry a valid slot write this cycle
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse: all DEPTH slots written
- len_err  out  1  one-cycle pulse: start rejected for illegal len

## Operation
- States: IDLE, LOAD, PAD, DONE. Slot index idx (SEL_W+1 bits) and latched length L.
- IDLE: start=1 with 1<=len<=DEPTH -> latch L=len, idx=0, go LOAD. start=1 with len=0 or len>DEPTH -> len_err pulse, stay IDLE, no writes.
- LOAD: in_ready=1 (combinational from state). Transfer when in_valid&&in_ready: register sel_out=idx, data_out=in_data, wr_en=1; idx++. On the transfer of sample L: go PAD if L<DEPTH, else DONE.
- PAD: in_ready=0. Every cycle register sel_out=idx, data_out=0, wr_en=1; idx++. The write of slot DEPTH-1 -> DONE.
- DONE: one cycle; frame_done=1 for exactly one cycle, namely the cycle immediately after the final wr_en cycle; -> IDLE.
- wr_en=0 in any cycle without a write; sel_out/data_out hold their last values when wr_en=0.
- busy=1 in LOAD, PAD, DONE; 0 in IDLE. start while busy is ignored (no len_err).
- abort=1 in LOAD or PAD: -> IDLE next edge; wr_en=0 from the next cycle; writes already issued stand; no frame_done. Transfer in the same cycle as abort is not accepted. abort in IDLE/DONE ignored (DONE still pulses frame_done).
- Every completed frame issues exactly DEPTH writes, slots 0..DEPTH-1 ascending, no repeats, no skips.

## Timing
- Reset (rst_n=0, async): state IDLE, idx=0, L=0; in_ready, sel_out, data_out, wr_en, busy, frame_done, len_err all 0.
- start sampled at edge e -> in_ready=1 and busy=1 from cycle after e.
- Transfer latency: write appears on sel_out/data_out/wr_en in the cycle after the accepting edge.
- Throughput: one sample per cycle in LOAD; one zero write per cycle in PAD; no bubble at LOAD->PAD.
- With in_valid held high, a frame yields DEPTH consecutive wr_en cycles, then frame_done next cycle; start-to-frame_done = DEPTH+2 cycles.
- Backpressure only via in_valid; in_ready never drops mid-LOAD except on abort or after sample L.

## Test plan
- Reset then start, len=64, in_valid held high, in_data=0x0100+i -> 64 consecutive wr_en, sel_out 0..63 with data 0x0100..0x013F, no zero writes, single frame_done after the last write, busy back to 0.
- start, len=5, data 0xA0..0xA4 -> in_ready high for 5 transfers only; sel 0..4 carry 0xA0..0xA4, sel 5..63 carry 0x0000; 64 writes total; frame_done once.
- start, len=8, in_valid toggled 1/0 each cycle -> wr_en gaps mirror gaps, sel 0..7 contiguous, then 56 back-to-back zero writes.
- start with len=0, then len=65 -> len_err pulse each, busy/wr_en stay 0; start while busy -> ignored, frame unaffected.
- len=10, abort after 3 transfers -> exactly 3 writes (sel 0..2), no frame_done, IDLE; next start len=2 writes from sel 0.
- rst_n asserted mid-PAD (idx=40) -> all outputs 0 immediately, IDLE after release; new start runs a full clean frame.
